// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its UART frame sequencer:
// FSM state encoding and the opcode values the ALU understands.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h04;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_operation,
  output logic [NB_DATA-1:0] o_result
);

  logic signed [NB_DATA-1:0] data_a_s;

  assign data_a_s = $signed(i_data_a);

  always_comb begin
    o_result = '0;
    case (i_operation)
      OP_ADD:  o_result = i_data_a + i_data_b;
      OP_SUB:  o_result = i_data_a - i_data_b;
      OP_AND:  o_result = i_data_a & i_data_b;
      OP_OR:   o_result = i_data_a | i_data_b;
      OP_XOR:  o_result = i_data_a ^ i_data_b;
      OP_NOR:  o_result = ~(i_data_a | i_data_b);
      OP_SRA:  o_result = data_a_s >>> i_data_b;
      OP_SRL:  o_result = i_data_a >> i_data_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/frame_timeout_counter.sv
// Inter-byte idle counter; saturates and flags expiry at TIMEOUT_CYCLES.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && !o_expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes from the UART, presents them to the ALU,
// and hands the result to the transmitter with a one-cycle start strobe.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_overrun
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   operation_q, operation_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;

  logic receiving, byte_accepted, tmo_expired, unused_rx_hi;

  // Opcode byte carries spare upper bits that are deliberately dropped.
  assign unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OP];

  assign receiving     = (state_q == ST_WAIT_A) || (state_q == ST_WAIT_B) ||
                         (state_q == ST_WAIT_OP);
  assign byte_accepted = receiving && i_rx_done;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (byte_accepted || (state_q == ST_WAIT_A)),
    .i_enable ((state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP)),
    .o_expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    operation_d = operation_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    overrun_d   = overrun_q | (i_rx_done && !receiving);
    case (state_q)
      ST_WAIT_A: if (i_rx_done) begin
        data_a_d = i_rx_data;
        state_d  = ST_WAIT_B;
      end
      // A byte arriving on the expiry cycle wins over the timeout.
      ST_WAIT_B: if (i_rx_done) begin
        data_b_d = i_rx_data;
        state_d  = ST_WAIT_OP;
      end else if (tmo_expired) begin
        state_d = ST_WAIT_A;
      end
      ST_WAIT_OP: if (i_rx_done) begin
        operation_d = i_rx_data[NB_OP-1:0];
        state_d     = ST_EXEC;
      end else if (tmo_expired) begin
        state_d = ST_WAIT_A;
      end
      ST_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_d = ST_WAIT_A;
      default:    state_d = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_WAIT_A;
      data_a_q    <= '0;
      data_b_q    <= '0;
      operation_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      operation_q <= operation_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_operation = operation_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_overrun   = overrun_q;

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Frame sequencer between the UART receiver/transmitter and the `alu` stage. It collects three received bytes (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a one-cycle start strobe. A per-byte inter-byte timeout discards stalled partial frames.

## Interface
Parameters:
- `NB_DATA`, 8, width of UART bytes, ALU operands and result
- `NB_OP`, 6, ALU opcode width
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle cycles allowed between bytes of one frame

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_rx_data`  in  NB_DATA  received byte; valid only while `i_rx_done`=1
- `i_rx_done`  in  1  one-cycle pulse, byte received
- `i_tx_done`  in  1  one-cycle pulse, transmitter finished the byte
- `i_alu_result`  in  NB_DATA  combinational ALU output
- `o_data_a`  out  NB_DATA  registered operand A to ALU
- `o_data_b`  out  NB_DATA  registered operand B to ALU
- `o_operation`  out  NB_OP  registered opcode to ALU
- `o_tx_data`  out  NB_DATA  registered result byte to transmitter
- `o_tx_start`  out  1  one-cycle transmit strobe
- `o_overrun`  out  1  sticky flag: a byte arrived while not accepting

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. Reset state is WAIT_A.
- WAIT_A, on `i_rx_done`: `o_data_a`<=`i_rx_data`, go to WAIT_B.
- WAIT_B, on `i_rx_done`: `o_data_b`<=`i_rx_data`, go to WAIT_OP.
- WAIT_OP, on `i_rx_done`: `o_operation`<=`i_rx_data[NB_OP-1:0]` (upper bits ignored), go to EXEC.
- EXEC: unconditional. `o_tx_data`<=`i_alu_result`, go to SEND.
- SEND: `o_tx_start`=1 for this cycle only, go to WAIT_TX.
- WAIT_TX, on `i_tx_done`: go to WAIT_A. Operand and opcode registers hold their values.
- Bytes are raw. The block performs no arithmetic and no opcode validation; an invalid opcode is transmitted as whatever the ALU returns (0).
- Timeout counter:
  - Cleared on every accepted byte and whenever the FSM is in WAIT_A.
  - Counts each cycle in WAIT_B and WAIT_OP.
  - On reaching `TIMEOUT_CYCLES` with no byte in that cycle: go to WAIT_A and clear the counter. Operand registers are not cleared.
- Simultaneous byte and timeout expiry in the same cycle: the byte is accepted and the timeout is not taken.
- `i_rx_done` in EXEC, SEND or WAIT_TX: the byte is dropped and `o_overrun`<=1. The flag is cleared only by reset.
- `i_tx_done` outside WAIT_TX is ignored.

## Timing
- Reset values: FSM state WAIT_A, counter 0, all outputs 0.
- Reset acts immediately: `o_tx_start` falls asynchronously; a partial frame and a pending transmission are abandoned.
- Each byte is registered on the clock edge that ends its `i_rx_done` cycle.
- Latency: opcode `i_rx_done` in cycle t → EXEC in t+1 (ALU inputs stable) → `o_tx_start`=1 in t+2 only, with `o_tx_data` valid from t+2 until the next frame's EXEC.
- Back-to-back bytes (`i_rx_done` on consecutive cycles) are accepted in WAIT_A, WAIT_B and WAIT_OP.
- Minimum frame period: 3 byte cycles + EXEC + SEND + transmit time.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`.

## Structure
- Shared package `alu_pkg`:
  - FSM state encoding localparams.
  - ALU opcode constants: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h04. These are used by `alu`, this block and the benches.
- One sub-module: `frame_timeout_counter` (inputs clear, enable; output expired), parameterised by `TIMEOUT_CYCLES`.
- The FSM and the data registers live in the top module.

## Test plan
Bench uses `TIMEOUT_CYCLES`=100 and the real `alu` connected.
- ADD frame: bytes 0x05, 0x03, 0x20 → `o_tx_start` exactly 2 cycles after the opcode byte, `o_tx_data`=0x08; after `i_tx_done`, state WAIT_A.
- SUB and SRA frames:
  - 0x03, 0x05, 0x22 → 0xFE.
  - 0x80, 0x02, 0x03 → 0xE0.
  - Opcode byte 0xE0 → only 0x20 reaches the ALU (ADD).
- Timeout: bytes 0x11, 0x22, then 101 idle cycles, then frame 0x0F, 0x3C, 0x24 → single transmission of 0x0C. Check a byte landing exactly on expiry is accepted.
- Overrun: byte 0xAA during WAIT_TX → `o_overrun`=1, `o_tx_data` unchanged, next frame processed normally, flag stays 1 until reset.
- Reset mid-frame and during SEND: all outputs 0 immediately, `o_tx_start` not re-issued; a following full frame is processed correctly.
- Invalid opcode 0x3F → transmitted 0x00; back-to-back `i_rx_done` for all three bytes is accepted.
